// File: rtl/btn_conditioner.sv
// Push-button conditioner: two-flop synchronizer, restartable debounce window,
// registered press/release edges and a hold FSM that classifies short vs long presses.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES   = 480000,
  parameter int LONG_PRESS_CYCLES = 96000000,
  parameter bit ACTIVE_LOW        = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic usr_btn,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_press,
  output logic long_press
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } hold_state_t;

  logic              s1;
  logic              s2;
  logic              lvl;
  logic [CNT_W-1:0]  cnt;
  logic              accept;
  logic              rise;
  logic              fall;

  hold_state_t       state;
  hold_state_t       state_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_cnt_nxt;
  logic              short_nxt;
  logic              long_nxt;

  // Synchronizer: flops idle at the released pin level so reset never looks like a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= ACTIVE_LOW;
      s2 <= ACTIVE_LOW;
    end else begin
      s1 <= usr_btn;
      s2 <= s1;
    end
  end

  assign lvl = ACTIVE_LOW ? ~s2 : s2;

  // Debounce: a level change is taken only after the window completes uninterrupted.
  assign accept = (lvl != pressed) && (cnt == CNT_LAST);
  assign rise   = accept && lvl;
  assign fall   = accept && !lvl;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= '0;
      pressed       <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= rise;
      release_pulse <= fall;
      if (lvl == pressed) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        pressed <= lvl;
        cnt     <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Hold FSM: steps on the unregistered edge events so its pulses line up with
  // press_pulse/release_pulse; a release on the threshold edge wins.
  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    short_nxt    = 1'b0;
    long_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt    = HELD;
          hold_cnt_nxt = '0;
        end
      end
      HELD: begin
        if (fall) begin
          short_nxt = 1'b1;
          state_nxt = IDLE;
        end else if (hold_cnt == HOLD_LAST) begin
          long_nxt  = 1'b1;
          state_nxt = LONG;
        end else begin
          hold_cnt_nxt = hold_cnt + 1'b1;
        end
      end
      LONG: begin
        if (fall) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      short_press <= 1'b0;
      long_press  <= 1'b0;
    end else begin
      state       <= state_nxt;
      hold_cnt    <= hold_cnt_nxt;
      short_press <= short_nxt;
      long_press  <= long_nxt;
    end
  end

endmodule
